// File: rtl/tdm_demux2.sv
// tdm_demux2 -- two-channel time-division demultiplexer / frame assembler.
//
// Accepts a stream of samples tagged channel 0 / channel 1 (alternating),
// pairs each channel-0 sample with the following channel-1 sample and
// presents the pair on out0/out1 with a one-cycle out_valid strobe.
// Out-of-order samples raise a one-cycle seq_err pulse and the assembler
// resynchronises on the newest channel-0 sample.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    incoming multiplexed sample (WIDTH bits)
//   in_sel     channel tag of in_data (0 = ch0, 1 = ch1)
//   in_valid   qualifies in_data/in_sel
//   out0/out1  channel samples of the last completed frame (held between frames)
//   out_valid  one-cycle pulse: new frame on out0/out1
//   seq_err    one-cycle pulse: out-of-order sample received
//   err_cnt    saturating sequence-error count (only with TDM_DEMUX_ERR_CNT_EN)
//
// Optional feature macro: TDM_DEMUX_ERR_CNT_EN adds the err_cnt port and counter.
//
// Handshake: there is no backpressure. A sample is consumed on every rising
// edge where in_valid=1 and rst=0; out_valid/seq_err are registered pulses
// visible for exactly the cycle after the consuming edge.
//
// The FSM state is held in state_q (WAIT0 = expecting ch0, WAIT1 = expecting
// ch1) so checkers can bind to it hierarchically.

module tdm_demux2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  output logic             seq_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic {
    WAIT0 = 1'b0,
    WAIT1 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             out_valid_q, out_valid_d;
  logic             seq_err_q, seq_err_d;

  always_comb begin
    state_d     = state_q;
    hold0_d     = hold0_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        WAIT0: begin
          if (!in_sel) begin
            hold0_d = in_data;
            state_d = WAIT1;
          end else begin
            // ch1 with no pending ch0: drop it.
            seq_err_d = 1'b1;
          end
        end
        WAIT1: begin
          if (in_sel) begin
            out0_d      = hold0_q;
            out1_d      = in_data;
            out_valid_d = 1'b1;
            state_d     = WAIT0;
          end else begin
            // Repeated ch0: keep the newest one so a frame never pairs stale data.
            seq_err_d = 1'b1;
            hold0_d   = in_data;
          end
        end
        default: state_d = WAIT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT0;
      hold0_q     <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold0_q     <= hold0_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;
  assign seq_err   = seq_err_q;

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (seq_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2 -- self-checking bench for tdm_demux2.
// Driver tasks push expected events into exp_q; a monitor process pops them
// when the DUT pulses out_valid/seq_err and checks held outputs every cycle.
// Optional TDM_DEMUX_ERR_CNT_EN also checks err_cnt.

module tb_tdm_demux2;

  localparam int W  = 4;
  localparam int EW = 2 * W + 1;   // {is_err, d0, d1}

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         in_valid = 1'b1;
  logic [W-1:0] out0, out1;
  logic         out_valid, seq_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  tdm_demux2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid),
    .seq_err   (seq_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            done  = 1'b0;

  // Reference model: at most one pending channel-0 sample.
  bit            pend_vld = 1'b0;
  logic [W-1:0]  pend_dat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    if (v) begin
      if (!s) begin
        if (pend_vld) exp_q.push_back({1'b1, {W{1'b0}}, {W{1'b0}}});
        pend_vld = 1'b1;
        pend_dat = d;
      end else if (pend_vld) begin
        exp_q.push_back({1'b0, pend_dat, d});
        pend_vld = 1'b0;
      end else begin
        exp_q.push_back({1'b1, {W{1'b0}}, {W{1'b0}}});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0);
  endtask

  // Reset with a valid input applied: that sample must be lost.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
    end
    pend_vld = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0]  cur0 = '0;
    logic [W-1:0]  cur1 = '0;
    int            cnt  = 0;
    logic [EW-1:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (rst) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        cur0 = '0;
        cur1 = '0;
        cnt  = 0;
      end else begin
        if (out_valid && seq_err) chk("pulse_exclusive", 64'd1, 64'd0);
        if (out_valid || seq_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {62'd0, out_valid, seq_err}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind_seq_err", 64'(seq_err), 64'(e[EW-1]));
            if (!e[EW-1]) begin
              cur0 = e[2*W-1:W];
              cur1 = e[W-1:0];
            end else if (cnt < 255) begin
              cnt++;
            end
          end
        end else begin
          chk("missing_pulse", 64'(exp_q.size()), 64'd0);
          exp_q.delete();
        end
      end
      chk("out0", 64'(out0), 64'(cur0));
      chk("out1", 64'(out1), 64'(cur1));
`ifdef TDM_DEMUX_ERR_CNT_EN
      chk("err_cnt", 64'(err_cnt), 64'(cnt));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    // Reset for 2 cycles with valid input applied.
    do_reset(2);
    // First sample after release treated as ch0.
    send(1, 0, 4'h1); send(1, 1, 4'h0); send(1, 0, 4'h0); send(1, 1, 4'h1);
    idle(2);
    // Idle gaps inside a frame.
    send(1, 0, 4'h1); idle(3); send(1, 1, 4'h1);
    idle(1);
    // Sequence errors and resync to newest ch0.
    send(1, 1, 4'h1);
    send(1, 0, 4'h0); send(1, 0, 4'h1); send(1, 1, 4'h0);
    idle(1);
    // Reset mid-frame discards the pending ch0.
    send(1, 0, 4'h1); do_reset(1); send(1, 1, 4'h0);
    idle(1);
    // Error counter saturation (300 errors), then reset clears it.
    for (int i = 0; i < 300; i++) send(1, 1, W'($urandom));
    idle(2);
    do_reset(1);
    idle(2);
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
      else send($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), W'($urandom));
    end
    idle(3);
    @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
